// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-latency fetch port plus a byte-stream program loader.
// Optional macro IMEM_FAULT_EN: misaligned/out-of-range fetches return NOP and set fetch_fault.
module imem_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_read,
    output logic [31:0] imem_data,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done,
    output logic        load_err,
    output logic        cpu_hold,
    output logic        fetch_fault
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [AW:0]   word_cnt;
    logic [23:0]   byte_buf;
    logic [31:0]   hold_q;
    logic [31:0]   mem [MEM_WORDS];

    logic          take;
    logic          overflow;
    logic          wr_en;
    logic [31:0]   wr_word;
    logic [AW-1:0] rd_idx;
    logic          bad_addr;
    logic [31:0]   rd_word;

    assign take     = (state == LOAD) && load_valid;
    // word_cnt saturates at MEM_WORDS; its top bit marks the array as full
    assign overflow = word_cnt[AW];
    assign wr_en    = take && !overflow && ((byte_cnt == 2'd3) || load_last);

    always_comb begin
        wr_word = 32'h0;
        case (byte_cnt)
            2'd0:    wr_word = {24'h0, load_byte};
            2'd1:    wr_word = {16'h0, load_byte, byte_buf[7:0]};
            2'd2:    wr_word = {8'h0, load_byte, byte_buf[15:0]};
            default: wr_word = {load_byte, byte_buf[23:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_cnt[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (take && !overflow) begin
            case (byte_cnt)
                2'd0:    byte_buf[7:0]   <= load_byte;
                2'd1:    byte_buf[15:8]  <= load_byte;
                2'd2:    byte_buf[23:16] <= load_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            load_err   <= 1'b0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            cpu_hold   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        byte_cnt   <= 2'd0;
                        word_cnt   <= '0;
                        load_err   <= 1'b0;
                        load_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        if (overflow) begin
                            load_err <= 1'b1;
                        end else if ((byte_cnt == 2'd3) || load_last) begin
                            byte_cnt <= 2'd0;
                            word_cnt <= word_cnt + 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                        if (load_last) begin
                            state      <= COMMIT;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

    assign rd_idx = imem_addr[AW+1:2];

`ifdef IMEM_FAULT_EN
    assign bad_addr = (imem_addr[1:0] != 2'b00) || ((imem_addr >> (AW + 2)) != 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_fault <= 1'b0;
        end else if ((state == IDLE) && imem_read && bad_addr) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^{imem_addr[1:0], imem_addr[31:AW+2]};
    assign bad_addr    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign rd_word = bad_addr ? NOP_WORD : mem[rd_idx];

    always_comb begin
        imem_data = hold_q;
        if (state != IDLE) begin
            imem_data = NOP_WORD;
        end else if (imem_read) begin
            imem_data = rd_word;
        end
    end

    // Last returned word, replayed while fetch is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= NOP_WORD;
        end else if ((state == IDLE) && imem_read) begin
            hold_q <= rd_word;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a byte-image reference model.
`timescale 1ns/1ps
module tb_imem_responder;
    localparam int          MW  = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr = 32'h0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_data;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic        load_err;
    logic        cpu_hold;
    logic        fetch_fault;

    always #5 clk = ~clk;

    imem_responder #(.MEM_WORDS(MW), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_read(imem_read), .imem_data(imem_data),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_err(load_err), .cpu_hold(cpu_hold), .fetch_fault(fetch_fault)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_seen = 0;
    logic [31:0] mdl [MW];
    bit          mval [MW];
    logic [31:0] m_hold;
    bit [7:0]    img[$];

    always @(negedge clk) if (load_done) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word w of the image holds bytes 4w..4w+3 little-endian; a trailing partial word is zero padded
    task automatic model_commit(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            int w;
            w = i / 4;
            if (w < MW) begin
                if (i % 4 == 0) begin
                    mdl[w]  = 32'h0;
                    mval[w] = 1'b1;
                end
                mdl[w][8*(i%4) +: 8] = img[i];
            end
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        imem_addr = a;
        imem_read = 1'b1;
        #1 chk(tag, imem_data, exp);
        m_hold = exp;
    endtask

    task automatic check_hold();
        @(negedge clk);
        imem_read = 1'b0;
        imem_addr = $urandom;
        #1 chk("hold_replay", imem_data, m_hold);
    endtask

    task automatic run_load(input int gap_pct);
        int d0;
        d0 = done_seen;
        @(negedge clk);
        imem_read  = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        chk("ready_in_load", 32'(load_ready), 32'd1);
        chk("hold_in_load", 32'(cpu_hold), 32'd1);
        imem_read = 1'b1;
        imem_addr = $urandom_range(0, MW - 1) * 4;
        #1 chk("nop_in_load", imem_data, NOP);
        for (int i = 0; i < img.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                load_valid = 1'b0;
                load_start = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                load_start = 1'b0;
                #1 chk("ready_gap", 32'(load_ready), 32'd1);
            end
            load_valid = 1'b1;
            load_byte  = img[i];
            load_last  = (i == img.size() - 1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        chk("done_pulse", 32'(load_done), 32'd1);
        chk("hold_commit", 32'(cpu_hold), 32'd1);
        chk("ready_commit", 32'(load_ready), 32'd0);
        chk("nop_commit", imem_data, NOP);
        imem_read = 1'b0;
        @(negedge clk);
        #1;
        chk("done_low", 32'(load_done), 32'd0);
        chk("hold_low", 32'(cpu_hold), 32'd0);
        chk("done_count", 32'(done_seen - d0), 32'd1);
        chk("load_err", 32'(load_err), 32'(img.size() > 4 * MW));
        chk("hold_after_load", imem_data, m_hold);
        model_commit(img.size());
    endtask

    task automatic reset_mid_load(input int k);
        int d0;
        d0 = done_seen;
        img = {};
        for (int i = 0; i < k; i++) img.push_back(8'($urandom));
        @(negedge clk);
        imem_read  = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < k; i++) begin
            load_valid = 1'b1;
            load_byte  = img[i];
            @(negedge clk);
        end
        load_valid = 1'b0;
        reset      = 1'b0;
        #1;
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_nop", imem_data, NOP);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 chk("rst_no_done", 32'(done_seen - d0), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        m_hold = NOP;
        model_commit(4 * (k / 4));
        for (int w = 0; w < MW; w++) if (mval[w]) fetch(w * 4, mdl[w], "rst_keep");
    endtask

    initial begin
        for (int w = 0; w < MW; w++) mval[w] = 1'b0;
        m_hold = NOP;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", 32'(load_ready), 32'd0);
        chk("reset_done", 32'(load_done), 32'd0);
        chk("reset_err", 32'(load_err), 32'd0);
        chk("reset_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reset_fault", 32'(fetch_fault), 32'd0);
        chk("reset_data", imem_data, NOP);
        @(negedge clk);
        reset = 1'b1;

        img = {8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load(0);
        fetch(32'h0, 32'h00100513, "plan_word0");
        fetch(32'h4, 32'h00200593, "plan_word1");
        check_hold();

        img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        run_load(20);
        fetch(32'h0, 32'hDDCCBBAA, "pad_word0");
        fetch(32'h4, 32'h00002211, "pad_word1");
        check_hold();

        img = {};
        for (int i = 0; i < 4 * MW + 4; i++) img.push_back(8'($urandom));
        run_load(10);
        for (int w = 0; w < MW; w++)
            fetch(w * 4, {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]}, "ovf_word");

        img = {8'h5A};
        run_load(0);
        fetch(32'h0, 32'h0000005A, "one_byte");

        for (int n = 0; n < 6; n++) begin
            img = {};
            for (int i = $urandom_range(1, 4 * MW + 6); i > 0; i--) img.push_back(8'($urandom));
            run_load($urandom_range(0, 40));
            for (int f = 0; f < 8; f++) begin
                int w;
                w = $urandom_range(0, MW - 1);
                fetch(w * 4, mdl[w], "rand_fetch");
                if ($urandom_range(0, 1) == 1) check_hold();
            end
        end

        reset_mid_load(2);
        reset_mid_load($urandom_range(3, 9));

`ifdef IMEM_FAULT_EN
        fetch(32'h4, mdl[1], "fault_ok");
        @(negedge clk);
        #1 chk("no_fault_yet", 32'(fetch_fault), 32'd0);
        fetch(32'h2, NOP, "fault_misalign");
        check_hold();
        #1 chk("fault_set", 32'(fetch_fault), 32'd1);
        fetch(MW * 4 + 4, NOP, "fault_range");
        fetch(32'h4, mdl[1], "fault_sticky_fetch");
        #1 chk("fault_sticky", 32'(fetch_fault), 32'd1);
`else
        fetch(MW * 4 + 4, mdl[1], "wrap_high");
        fetch(32'h7, mdl[1], "wrap_lowbits");
        fetch(32'hFFFF_FFC4, mdl[1], "wrap_top");
        check_hold();
        #1 chk("fault_tied", 32'(fetch_fault), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
